// File: rtl/pe_rx_checker.sv
// pe_rx_checker: receive-side endpoint for one NoC PE port.
// Sinks packets from the router and checks that each is addressed to this PE.
// Tracks per-source packet-number ordering, measures latency against a
// free-running cycle counter, and keeps saturating running statistics.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_valid, i_data   packet from router {dest_x, dest_y, pkt_no, data}
//   o_ready           sink ready (enable && !stall)
//   enable            allow acceptance
//   clear             synchronous statistics clear
//   rec_valid         one-cycle pulse per accepted packet
//   rec_src           {src_x, src_y} of the last accepted packet
//   rec_pkt_no        pkt_no of the last accepted packet
//   rec_latency       latency of the last accepted packet
//   receive_count     packets accepted (saturating)
//   max_latency       largest latency seen
//   latency_sum       sum of latencies (saturating)
//   err_count         packets with any error (saturating)
//   dest_err, seq_err sticky error flags
module pe_rx_checker #(
    parameter int X                 = 8,
    parameter int Y                 = 8,
    parameter int data_width        = 256,
    parameter int pkt_no_field_size = 12,
    parameter int my_x              = 0,
    parameter int my_y              = 0,
    parameter int stall_period      = 0,
    localparam int x_size      = $clog2(X),
    localparam int y_size      = $clog2(Y),
    localparam int total_width = x_size + y_size + pkt_no_field_size + data_width
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic [total_width-1:0]       i_data,
    output logic                         o_ready,
    input  logic                         enable,
    input  logic                         clear,
    output logic                         rec_valid,
    output logic [x_size+y_size-1:0]     rec_src,
    output logic [pkt_no_field_size-1:0] rec_pkt_no,
    output logic [31:0]                  rec_latency,
    output logic [31:0]                  receive_count,
    output logic [31:0]                  max_latency,
    output logic [47:0]                  latency_sum,
    output logic [15:0]                  err_count,
    output logic                         dest_err,
    output logic                         seq_err
);

    localparam int          entries    = X * Y;
    localparam int          idx_w      = (entries > 1) ? $clog2(entries) : 1;
    localparam logic [31:0] stall_last = (stall_period > 0) ? 32'(stall_period - 1) : '0;

    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [pkt_no_field_size-1:0] exp_q [entries];
    logic [pkt_no_field_size-1:0] exp_d [entries];

    logic                         rec_valid_q, rec_valid_d;
    logic [x_size+y_size-1:0]     rec_src_q, rec_src_d;
    logic [pkt_no_field_size-1:0] rec_pkt_no_q, rec_pkt_no_d;
    logic [31:0]                  rec_latency_q, rec_latency_d;
    logic [31:0]                  receive_count_q, receive_count_d;
    logic [31:0]                  max_latency_q, max_latency_d;
    logic [47:0]                  latency_sum_q, latency_sum_d;
    logic [15:0]                  err_count_q, err_count_d;
    logic                         dest_err_q, dest_err_d;
    logic                         seq_err_q, seq_err_d;

    logic [x_size-1:0]            dest_x, src_x;
    logic [y_size-1:0]            dest_y, src_y;
    logic [pkt_no_field_size-1:0] pkt_no;
    logic [31:0]                  inject_ts, latency;
    logic [idx_w-1:0]             tbl_idx;
    logic                         stall, accept, dest_mis, seq_mis;
    logic [48:0]                  sum_ext;
    logic                         unused_bits;

    assign dest_x    = i_data[total_width-1 -: x_size];
    assign dest_y    = i_data[total_width-1-x_size -: y_size];
    assign pkt_no    = i_data[data_width +: pkt_no_field_size];
    assign inject_ts = i_data[31:0];
    assign src_x     = i_data[32 +: x_size];
    assign src_y     = i_data[32+x_size +: y_size];
    // Payload filler above the source fields carries no meaning here.
    assign unused_bits = ^i_data;

    assign tbl_idx  = idx_w'(32'(src_y) * 32'(X) + 32'(src_x));
    assign latency  = cycle_cnt_q - inject_ts;
    assign dest_mis = {dest_x, dest_y} != {x_size'(my_x), y_size'(my_y)};
    assign seq_mis  = pkt_no != exp_q[tbl_idx];

    assign stall   = (stall_period != 0) && (stall_cnt_q == stall_last);
    assign o_ready = enable && !stall;
    assign accept  = i_valid && o_ready;

    always_comb begin
        cycle_cnt_d     = cycle_cnt_q + 32'd1;
        stall_cnt_d     = '0;
        if (stall_period != 0 && stall_cnt_q != stall_last) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        exp_d           = exp_q;
        rec_valid_d     = 1'b0;
        rec_src_d       = rec_src_q;
        rec_pkt_no_d    = rec_pkt_no_q;
        rec_latency_d   = rec_latency_q;
        receive_count_d = receive_count_q;
        max_latency_d   = max_latency_q;
        latency_sum_d   = latency_sum_q;
        err_count_d     = err_count_q;
        dest_err_d      = dest_err_q;
        seq_err_d       = seq_err_q;
        sum_ext         = '0;

        // Clear first so a packet accepted on the same edge lands on zeroed stats.
        if (clear) begin
            receive_count_d = '0;
            max_latency_d   = '0;
            latency_sum_d   = '0;
            err_count_d     = '0;
            dest_err_d      = 1'b0;
            seq_err_d       = 1'b0;
        end

        if (accept) begin
            rec_valid_d   = 1'b1;
            rec_src_d     = {src_x, src_y};
            rec_pkt_no_d  = pkt_no;
            rec_latency_d = latency;
            // Always resync to pkt_no+1 so one gap yields a single error.
            exp_d[tbl_idx] = pkt_no + pkt_no_field_size'(1);
            if (receive_count_d != '1) begin
                receive_count_d = receive_count_d + 32'd1;
            end
            if (latency > max_latency_d) begin
                max_latency_d = latency;
            end
            sum_ext       = {1'b0, latency_sum_d} + {17'd0, latency};
            latency_sum_d = sum_ext[48] ? '1 : sum_ext[47:0];
            if ((dest_mis || seq_mis) && err_count_d != '1) begin
                err_count_d = err_count_d + 16'd1;
            end
            if (dest_mis) dest_err_d = 1'b1;
            if (seq_mis)  seq_err_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q     <= '0;
            stall_cnt_q     <= '0;
            for (int unsigned i = 0; i < entries; i++) begin
                exp_q[i] <= '0;
            end
            rec_valid_q     <= 1'b0;
            rec_src_q       <= '0;
            rec_pkt_no_q    <= '0;
            rec_latency_q   <= '0;
            receive_count_q <= '0;
            max_latency_q   <= '0;
            latency_sum_q   <= '0;
            err_count_q     <= '0;
            dest_err_q      <= 1'b0;
            seq_err_q       <= 1'b0;
        end else begin
            cycle_cnt_q     <= cycle_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            exp_q           <= exp_d;
            rec_valid_q     <= rec_valid_d;
            rec_src_q       <= rec_src_d;
            rec_pkt_no_q    <= rec_pkt_no_d;
            rec_latency_q   <= rec_latency_d;
            receive_count_q <= receive_count_d;
            max_latency_q   <= max_latency_d;
            latency_sum_q   <= latency_sum_d;
            err_count_q     <= err_count_d;
            dest_err_q      <= dest_err_d;
            seq_err_q       <= seq_err_d;
        end
    end

    assign rec_valid     = rec_valid_q;
    assign rec_src       = rec_src_q;
    assign rec_pkt_no    = rec_pkt_no_q;
    assign rec_latency   = rec_latency_q;
    assign receive_count = receive_count_q;
    assign max_latency   = max_latency_q;
    assign latency_sum   = latency_sum_q;
    assign err_count     = err_count_q;
    assign dest_err      = dest_err_q;
    assign seq_err       = seq_err_q;

endmodule

// File: tb/tb_pe_rx_checker.sv
// tb_pe_rx_checker: scoreboard bench for pe_rx_checker (8x8 mesh, PE at (2,3),
// stall every 4th cycle). The driver predicts acceptance and expected results
// from a behavioural model and queues them; a monitor compares on rec_valid.
module tb_pe_rx_checker;

    localparam int X   = 8;
    localparam int Y   = 8;
    localparam int DW  = 256;
    localparam int PW  = 12;
    localparam int MYX = 2;
    localparam int MYY = 3;
    localparam int SP  = 4;
    localparam int TW  = 3 + 3 + PW + DW;

    logic          clk, rst, i_valid, o_ready, enable, clear;
    logic [TW-1:0] i_data;
    logic          rec_valid, dest_err, seq_err;
    logic [5:0]    rec_src;
    logic [PW-1:0] rec_pkt_no;
    logic [31:0]   rec_latency, receive_count, max_latency;
    logic [47:0]   latency_sum;
    logic [15:0]   err_count;

    pe_rx_checker #(
        .X(X), .Y(Y), .data_width(DW), .pkt_no_field_size(PW),
        .my_x(MYX), .my_y(MYY), .stall_period(SP)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .enable(enable), .clear(clear),
        .rec_valid(rec_valid), .rec_src(rec_src), .rec_pkt_no(rec_pkt_no),
        .rec_latency(rec_latency), .receive_count(receive_count),
        .max_latency(max_latency), .latency_sum(latency_sum),
        .err_count(err_count), .dest_err(dest_err), .seq_err(seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since reset release == value the cycle counter should hold.
    int unsigned k;
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    typedef struct {
        logic [2:0]  dx, dy, sx, sy;
        logic [11:0] pn;
        logic [31:0] ts;
    } pkt_t;

    typedef struct {
        int unsigned due;
        logic [5:0]  src;
        logic [11:0] pn;
        logic [31:0] lat, rc, maxl;
        logic [47:0] sum;
        logic [15:0] ec;
        logic        de, se;
    } rec_t;

    rec_t sbq[$];
    int unsigned n_checks = 0, n_pass = 0, pulses = 0;

    // Reference model state.
    logic [11:0] m_exp [64];
    logic [31:0] m_rc, m_max;
    logic [47:0] m_sum;
    logic [15:0] m_ec;
    logic        m_de, m_se;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_exp[i] = '0;
        m_rc = '0; m_max = '0; m_sum = '0; m_ec = '0; m_de = 1'b0; m_se = 1'b0;
    endtask

    function automatic logic [TW-1:0] build(input pkt_t p);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        d[31:0]  = p.ts;
        d[34:32] = p.sx;
        d[37:35] = p.sy;
        return {p.dx, p.dy, p.pn, d};
    endfunction

    function automatic pkt_t mk(input int dx, input int dy, input int sx, input int sy,
                                input int pn, input logic [31:0] ts);
        pkt_t p;
        p.dx = 3'(dx); p.dy = 3'(dy); p.sx = 3'(sx); p.sy = 3'(sy);
        p.pn = 12'(pn); p.ts = ts;
        return p;
    endfunction

    // Mostly well-formed traffic with occasional wrong destination/sequence/timestamp.
    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.sx = 3'($urandom()); p.sy = 3'($urandom());
        p.pn = ($urandom_range(0, 7) == 0) ? 12'($urandom()) : m_exp[int'(p.sy) * X + int'(p.sx)];
        if ($urandom_range(0, 7) == 0) begin p.dx = 3'($urandom()); p.dy = 3'($urandom()); end
        else begin p.dx = 3'(MYX); p.dy = 3'(MYY); end
        p.ts = ($urandom_range(0, 9) == 0) ? 32'($urandom()) : k - 32'($urandom_range(0, 63));
        return p;
    endfunction

    // Called at a negedge; drives one cycle, predicts its outcome, returns at the next negedge.
    task automatic drive(input logic v, input pkt_t p, input logic en, input logic clr,
                         output logic acc, output logic rdy);
        logic        ready_m, db, sb;
        logic [31:0] lat;
        longint unsigned s;
        int          idx;
        rec_t        r;
        i_valid = v; i_data = build(p); enable = en; clear = clr;
        #1;
        ready_m = en && ((k % SP) != SP - 1);
        rdy = o_ready;
        chk("o_ready", o_ready, ready_m);
        if (clr) begin
            m_rc = '0; m_max = '0; m_sum = '0; m_ec = '0; m_de = 1'b0; m_se = 1'b0;
        end
        acc = v && ready_m;
        if (acc) begin
            lat = k - p.ts;
            db  = (p.dx != 3'(MYX)) || (p.dy != 3'(MYY));
            idx = int'(p.sy) * X + int'(p.sx);
            sb  = p.pn != m_exp[idx];
            m_exp[idx] = p.pn + 12'd1;
            if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
            if (lat > m_max) m_max = lat;
            s = longint'(m_sum) + longint'(lat);
            m_sum = (s > 64'hFFFF_FFFF_FFFF) ? 48'hFFFF_FFFF_FFFF : s[47:0];
            if ((db || sb) && m_ec != 16'hFFFF) m_ec = m_ec + 1;
            m_de = m_de | db;
            m_se = m_se | sb;
            r.due = k + 1; r.src = {p.sx, p.sy}; r.pn = p.pn; r.lat = lat;
            r.rc = m_rc; r.maxl = m_max; r.sum = m_sum; r.ec = m_ec; r.de = m_de; r.se = m_se;
            sbq.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic clr);
        logic a, rdy;
        drive(1'b0, rand_pkt(), 1'b1, clr, a, rdy);
    endtask

    task automatic send(input pkt_t p);
        logic a, rdy;
        a = 1'b0;
        for (int t = 0; t < 8 && !a; t++) drive(1'b1, p, 1'b1, 1'b0, a, rdy);
    endtask

    task automatic check_zero();
        chk("rst_rec_valid", rec_valid, 0);
        chk("rst_rec_src", rec_src, 0);
        chk("rst_rec_pkt_no", rec_pkt_no, 0);
        chk("rst_rec_latency", rec_latency, 0);
        chk("rst_receive_count", receive_count, 0);
        chk("rst_max_latency", max_latency, 0);
        chk("rst_latency_sum", latency_sum, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_dest_err", dest_err, 0);
        chk("rst_seq_err", seq_err, 0);
    endtask

    // Monitor: compares DUT output against the queued expectation.
    initial begin
        rec_t r;
        logic expect_v;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                expect_v = (sbq.size() > 0) && (sbq[0].due == k);
                if (rec_valid) pulses++;
                if (rec_valid || expect_v) begin
                    chk("rec_valid", rec_valid, expect_v);
                    if (expect_v) begin
                        r = sbq.pop_front();
                        if (rec_valid) begin
                            chk("rec_src", rec_src, r.src);
                            chk("rec_pkt_no", rec_pkt_no, r.pn);
                            chk("rec_latency", rec_latency, r.lat);
                            chk("receive_count", receive_count, r.rc);
                            chk("max_latency", max_latency, r.maxl);
                            chk("latency_sum", latency_sum, r.sum);
                            chk("err_count", err_count, r.ec);
                            chk("dest_err", dest_err, r.de);
                            chk("seq_err", seq_err, r.se);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic a, rdy;
        int unsigned base, lows, pn;
        pkt_t p;
        rst = 1'b1; i_valid = 1'b0; i_data = '0; enable = 1'b0; clear = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_zero();
        @(negedge clk);
        rst = 1'b0;

        // First packet at cycle 10 from (0,0), injected at 0.
        while (k != 10) idle(1'b0);
        send(mk(MYX, MYY, 0, 0, 0, 0));
        chk("t1_rec_valid", rec_valid, 1);
        chk("t1_latency", rec_latency, 10);
        chk("t1_receive_count", receive_count, 1);
        chk("t1_max_latency", max_latency, 10);
        chk("t1_latency_sum", latency_sum, 10);
        chk("t1_err_count", err_count, 0);

        // Sequence gap from (1,1): only pkt_no 3 flags.
        send(mk(MYX, MYY, 1, 1, 0, k - 3));
        send(mk(MYX, MYY, 1, 1, 1, k - 4));
        chk("t2_seq_err_before_gap", seq_err, 0);
        send(mk(MYX, MYY, 1, 1, 3, k - 5));
        chk("t2_seq_err_gap", seq_err, 1);
        chk("t2_err_count_gap", err_count, 1);
        send(mk(MYX, MYY, 1, 1, 4, k - 6));
        chk("t2_err_count_after", err_count, 1);
        chk("t2_receive_count", receive_count, 5);

        // Prime (2,2) to expect 4095, clear, then wrap 4095 -> 0 and a wrong destination.
        send(mk(MYX, MYY, 2, 2, 4094, k - 2));
        idle(1'b1);
        chk("t3_clear_count", receive_count, 0);
        chk("t3_clear_seq_err", seq_err, 0);
        send(mk(MYX, MYY, 2, 2, 4095, k - 2));
        send(mk(MYX, MYY, 2, 2, 0, k - 2));
        chk("t3_wrap_seq_err", seq_err, 0);
        send(mk(5, 5, 2, 2, 1, k - 2));
        chk("t3_dest_err", dest_err, 1);
        chk("t3_err_count", err_count, 1);
        chk("t3_receive_count", receive_count, 3);
        chk("t3_seq_err", seq_err, 0);

        // Valid held high 16 cycles against stall_period 4.
        base = pulses; lows = 0; pn = 0;
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, mk(MYX, MYY, 4, 4, int'(pn), k), 1'b1, 1'b0, a, rdy);
            if (!rdy) lows++;
            if (a) pn++;
        end
        chk("t4_pulses", pulses - base, 12);
        chk("t4_ready_low", lows, 4);

        // Random traffic, including enable gaps and stray clears.
        for (int c = 0; c < 200; c++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_pkt(), 1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 31) == 0), a, rdy);
        end

        // 50 packets after a clear, then clear coincident with a latency-7 accept.
        idle(1'b1);
        for (int c = 0; c < 50; c++) send(rand_pkt());
        chk("t5_count50", receive_count, 50);
        while ((k % SP) == SP - 1) idle(1'b0);
        p = mk(MYX, MYY, 6, 6, 0, k - 7);
        p.pn = m_exp[6 * X + 6];
        drive(1'b1, p, 1'b1, 1'b1, a, rdy);
        chk("t5_receive_count", receive_count, 1);
        chk("t5_max_latency", max_latency, 7);
        chk("t5_latency_sum", latency_sum, 7);
        chk("t5_dest_err", dest_err, 0);
        chk("t5_seq_err", seq_err, 0);

        // Asynchronous reset between edges.
        for (int c = 0; c < 5; c++) send(rand_pkt());
        i_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_zero();
        model_reset();
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        send(mk(MYX, MYY, 0, 0, 0, k));
        send(mk(MYX, MYY, 1, 1, 0, k));
        send(mk(MYX, MYY, 2, 2, 0, k));
        send(mk(MYX, MYY, 7, 7, 0, k));
        chk("t6_err_count", err_count, 0);
        chk("t6_seq_err", seq_err, 0);
        chk("t6_receive_count", receive_count, 4);
        idle(1'b0);
        idle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
